// File: rtl/rr_hb_pkg.sv
// Shared sizing helpers and entry-kind encoding for the counting happen-before encoder.
// Entry layout, LSB first: logb_valid bits, per-channel loge counts, then payload.
package rr_hb_pkg;

  typedef enum logic [1:0] {
    ENT_NONE  = 2'd0,
    ENT_LOGB  = 2'd1,
    ENT_FLUSH = 2'd2
  } entry_kind_e;

  function automatic int hdr_width(input int logb_cnt, input int loge_cnt, input int cnt_w);
    return logb_cnt + loge_cnt * cnt_w;
  endfunction

  function automatic int full_width(input int logb_cnt, input int loge_cnt, input int cnt_w,
                                    input int data_w);
    return hdr_width(logb_cnt, loge_cnt, cnt_w) + data_w;
  endfunction

  // A flush entry carries only the header: no begin strobes, no payload.
  function automatic int flush_len(input int logb_cnt, input int loge_cnt, input int cnt_w);
    return hdr_width(logb_cnt, loge_cnt, cnt_w);
  endfunction

endpackage

// File: rtl/ram_fifo_ft.sv
// First-word-fall-through RAM FIFO; 2-cycle write-to-visible latency with PIPELINE=1.
// Holds 2**PTR_WIDTH entries in total, accepts a write at full when a pop happens the same cycle.
module ram_fifo_ft #(
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 4,
  parameter int WATERMARK = 2,
  parameter int PIPELINE  = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_vld_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  output logic             wr_full_o,
  output logic             rd_vld_o,
  output logic [WIDTH-1:0] rd_dat_o,
  input  logic             rd_rdy_i,
  output logic             almful_o
);

  localparam int DEPTH = 2 ** PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] OCC_FULL = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] OCC_WM   = (PTR_WIDTH + 1)'(WATERMARK);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_WIDTH:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_WIDTH:0] occ_q, occ_d;
  logic               almful_q;
  logic               mem_empty, pop, wr_en, mem_rd;

  assign mem_empty = (wr_ptr_q == rd_ptr_q);
  assign pop       = rd_vld_o & rd_rdy_i;
  // Occupancy counts the output stage too, so total capacity is exactly DEPTH.
  assign wr_full_o = (occ_q == OCC_FULL) & ~pop;
  assign wr_en     = wr_vld_i & ~wr_full_o;
  assign occ_d     = occ_q + (PTR_WIDTH + 1)'(wr_en) - (PTR_WIDTH + 1)'(pop);
  assign almful_o  = almful_q;

  generate
    if (PIPELINE != 0) begin : g_pipe
      logic             vld_q;
      logic [WIDTH-1:0] dat_q;

      assign mem_rd   = ~mem_empty & (~vld_q | pop);
      assign rd_vld_o = vld_q;
      assign rd_dat_o = dat_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          vld_q <= 1'b0;
        end else if (mem_rd) begin
          vld_q <= 1'b1;
        end else if (pop) begin
          vld_q <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (mem_rd) begin
          dat_q <= mem_q[rd_ptr_q[PTR_WIDTH-1:0]];
        end
      end
    end else begin : g_comb
      assign mem_rd   = pop;
      assign rd_vld_o = ~mem_empty;
      assign rd_dat_o = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= wr_dat_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      almful_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + (PTR_WIDTH + 1)'(wr_en);
      rd_ptr_q <= rd_ptr_q + (PTR_WIDTH + 1)'(mem_rd);
      occ_q    <= occ_d;
      almful_q <= (occ_q >= OCC_WM);
    end
  end

endmodule

// File: rtl/rr_hb_counting_encoder.sv
// Folds standalone loge strobes into saturating per-channel counts attached to the next logb entry,
// emitting header-only flush entries on saturation or timeout; entries queue in a FWFT FIFO (2-cycle latency).
module rr_hb_counting_encoder
  import rr_hb_pkg::*;
#(
  parameter int LOGB_CHANNEL_CNT    = 8,
  parameter int LOGE_CHANNEL_CNT    = 8,
  parameter int LOGB_DATA_WIDTH     = 512,
  parameter int OFFSET_WIDTH        = 10,
  parameter int LOGE_CNT_WIDTH      = 2,
  parameter int FIFO_PTR_WIDTH      = 7,
  parameter int RECORDER_PIPE_DEPTH = 4,
  parameter int MERGE_TREE_HEIGHT   = 3,
  parameter int ALMFUL_THRESHOLD    = 2 * RECORDER_PIPE_DEPTH + 2 * MERGE_TREE_HEIGHT + 16,
  parameter int FLUSH_TIMEOUT       = 1024,
  localparam int FULL_WIDTH = full_width(LOGB_CHANNEL_CNT, LOGE_CHANNEL_CNT, LOGE_CNT_WIDTH,
                                         LOGB_DATA_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [LOGB_CHANNEL_CNT-1:0] in_logb_valid,
  input  logic [LOGE_CHANNEL_CNT-1:0] in_loge_valid,
  input  logic                        in_any_valid,
  input  logic [LOGB_DATA_WIDTH-1:0]  in_plogb_data,
  input  logic [OFFSET_WIDTH-1:0]     in_plogb_len,
  output logic                        in_logb_almful,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FULL_WIDTH-1:0]       out_data,
  output logic [OFFSET_WIDTH-1:0]     out_len,
  output logic                        err_cnt_oflow,
  output logic                        err_fifo_oflow
);

  localparam int HDR_W = hdr_width(LOGB_CHANNEL_CNT, LOGE_CHANNEL_CNT, LOGE_CNT_WIDTH);
  localparam int DEPTH = 2 ** FIFO_PTR_WIDTH;
  localparam int TMO_W = $clog2(FLUSH_TIMEOUT + 2);
  localparam logic [TMO_W-1:0]          TMO_LIMIT = TMO_W'(FLUSH_TIMEOUT);
  localparam logic [LOGE_CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [OFFSET_WIDTH-1:0]   HDR_LEN   =
    OFFSET_WIDTH'(flush_len(LOGB_CHANNEL_CNT, LOGE_CHANNEL_CNT, LOGE_CNT_WIDTH));

  generate
    if (FULL_WIDTH > 2 ** OFFSET_WIDTH - 1) begin : g_len_chk
      $error("OFFSET_WIDTH too narrow for FULL_WIDTH");
    end
    if (ALMFUL_THRESHOLD >= DEPTH) begin : g_thr_chk
      $error("ALMFUL_THRESHOLD must be below FIFO depth");
    end
  endgenerate

  typedef logic [LOGE_CHANNEL_CNT-1:0][LOGE_CNT_WIDTH-1:0] cnt_vec_t;

  cnt_vec_t                      cnt_q, cnt_d;
  logic [TMO_W-1:0]              tmo_q, tmo_d;
  logic                          err_cnt_q, err_fifo_q;
  logic                          cnt_sat, cnt_nz, cnt_lost, tmo_hit, flush_req;
  logic                          push, fifo_full;
  entry_kind_e                   kind;
  logic [FULL_WIDTH-1:0]         ent_dat;
  logic [OFFSET_WIDTH-1:0]       ent_len;
  logic [FULL_WIDTH+OFFSET_WIDTH-1:0] fifo_rd_dat;

  always_comb begin
    cnt_sat = 1'b0;
    cnt_nz  = 1'b0;
    for (int i = 0; i < LOGE_CHANNEL_CNT; i++) begin
      if (cnt_q[i] == CNT_MAX) cnt_sat = 1'b1;
      if (cnt_q[i] != '0)      cnt_nz  = 1'b1;
    end
    tmo_hit   = (FLUSH_TIMEOUT != 0) && (tmo_q == TMO_LIMIT);
    flush_req = cnt_sat | tmo_hit;

    // A logb always pushes; a flush only goes when the FIFO has room for it.
    if (in_any_valid)                 kind = ENT_LOGB;
    else if (flush_req && !fifo_full) kind = ENT_FLUSH;
    else                              kind = ENT_NONE;
    push = (kind != ENT_NONE);

    ent_dat = '0;
    ent_len = HDR_LEN;
    ent_dat[HDR_W-1:LOGB_CHANNEL_CNT] = cnt_q;
    if (kind == ENT_LOGB) begin
      ent_dat[LOGB_CHANNEL_CNT-1:0] = in_logb_valid;
      ent_dat[FULL_WIDTH-1:HDR_W]   = in_plogb_data;
      ent_len                       = in_plogb_len + HDR_LEN;
    end
  end

  // Ends arriving with a push belong after that entry, so they seed the fresh counts.
  always_comb begin
    cnt_d    = cnt_q;
    cnt_lost = 1'b0;
    for (int i = 0; i < LOGE_CHANNEL_CNT; i++) begin
      if (push) begin
        cnt_d[i] = LOGE_CNT_WIDTH'(in_loge_valid[i]);
      end else if (in_loge_valid[i]) begin
        if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
        else                     cnt_lost = 1'b1;
      end
    end
    if (push || !cnt_nz)        tmo_d = '0;
    else if (tmo_q != TMO_LIMIT) tmo_d = tmo_q + 1'b1;
    else                        tmo_d = tmo_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      tmo_q      <= '0;
      err_cnt_q  <= 1'b0;
      err_fifo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      if (cnt_lost)          err_cnt_q  <= 1'b1;
      if (push && fifo_full) err_fifo_q <= 1'b1;
    end
  end

  ram_fifo_ft #(
    .WIDTH     (FULL_WIDTH + OFFSET_WIDTH),
    .PTR_WIDTH (FIFO_PTR_WIDTH),
    .WATERMARK (DEPTH - ALMFUL_THRESHOLD),
    .PIPELINE  (1)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .wr_vld_i  (push),
    .wr_dat_i  ({ent_len, ent_dat}),
    .wr_full_o (fifo_full),
    .rd_vld_o  (out_valid),
    .rd_dat_o  (fifo_rd_dat),
    .rd_rdy_i  (out_ready),
    .almful_o  (in_logb_almful)
  );

  assign {out_len, out_data} = fifo_rd_dat;
  assign err_cnt_oflow       = err_cnt_q;
  assign err_fifo_oflow      = err_fifo_q;

endmodule

// File: tb/tb_rr_hb_counting_encoder.sv
// Bench for rr_hb_counting_encoder: vector table, directed corner sequences and a random run
// against a queue-based reference of the counting/flush rules.
module tb_rr_hb_counting_encoder;

  localparam int LB = 8, LE = 8, CW = 2, DW = 32, OW = 10, PW = 7;
  localparam int THR = 30, TMO = 16, DEPTH = 128;
  localparam int FW = LB + LE * CW + DW;
  localparam int HDR = LB + LE * CW;

  logic          clk = 1'b0;
  logic          rstn;
  logic [LB-1:0] b_logb;
  logic [LE-1:0] b_loge;
  logic          b_any;
  logic [DW-1:0] b_data;
  logic [OW-1:0] b_plen;
  logic          b_rdy;
  logic          almful, out_valid, err_cnt_oflow, err_fifo_oflow;
  logic [FW-1:0] out_data;
  logic [OW-1:0] out_len;

  rr_hb_counting_encoder #(
    .LOGB_CHANNEL_CNT (LB), .LOGE_CHANNEL_CNT (LE), .LOGB_DATA_WIDTH (DW),
    .OFFSET_WIDTH (OW), .LOGE_CNT_WIDTH (CW), .FIFO_PTR_WIDTH (PW),
    .ALMFUL_THRESHOLD (THR), .FLUSH_TIMEOUT (TMO)
  ) dut (
    .clk (clk), .rstn (rstn), .in_logb_valid (b_logb), .in_loge_valid (b_loge),
    .in_any_valid (b_any), .in_plogb_data (b_data), .in_plogb_len (b_plen),
    .in_logb_almful (almful), .out_valid (out_valid), .out_ready (b_rdy),
    .out_data (out_data), .out_len (out_len),
    .err_cnt_oflow (err_cnt_oflow), .err_fifo_oflow (err_fifo_oflow)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, n_pop = 0;
  int mcnt[LE];
  int mtmo;
  logic m_ecnt, m_efifo;
  logic [OW+FW-1:0] mq[$];

  typedef struct {
    logic [LE-1:0] pre_loge;
    logic [LB-1:0] logb;
    logic [DW-1:0] data;
    logic [OW-1:0] plen;
    logic [15:0]   exp_cnt;
    logic [OW-1:0] exp_len;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [OW+FW-1:0] act, input logic [OW+FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < LE; i++) mcnt[i] = 0;
    mtmo = 0;
    m_ecnt = 1'b0;
    m_efifo = 1'b0;
  endtask

  // Called at a falling edge with inputs set; evaluates the coming rising edge, then waits a cycle.
  task automatic step();
    logic pop, sat, allz, full, push;
    logic [OW+FW-1:0] e;
    check("err_cnt_oflow", err_cnt_oflow, m_ecnt);
    check("err_fifo_oflow", err_fifo_oflow, m_efifo);
    pop = out_valid && b_rdy;
    if (pop) begin
      n_pop++;
      if (mq.size() == 0) begin
        total++; bad++;
        $display("FAIL pop_unexpected: got entry %h expected none", {out_len, out_data});
      end else begin
        check("pop_entry", {out_len, out_data}, mq.pop_front());
      end
    end
    sat = 1'b0; allz = 1'b1;
    for (int i = 0; i < LE; i++) begin
      if (mcnt[i] == (1 << CW) - 1) sat = 1'b1;
      if (mcnt[i] != 0) allz = 1'b0;
    end
    full = (mq.size() >= DEPTH);
    push = b_any || ((sat || mtmo == TMO) && !full);
    if (push) begin
      e = '0;
      if (b_any) begin
        e[LB-1:0] = b_logb;
        e[HDR +: DW] = b_data;
        e[FW +: OW] = b_plen + OW'(HDR);
      end else begin
        e[FW +: OW] = OW'(HDR);
      end
      for (int i = 0; i < LE; i++) e[LB + CW*i +: CW] = CW'(mcnt[i]);
      if (full) m_efifo = 1'b1;
      else      mq.push_back(e);
    end
    for (int i = 0; i < LE; i++) begin
      if (push) mcnt[i] = int'(b_loge[i]);
      else if (b_loge[i]) begin
        if (mcnt[i] < (1 << CW) - 1) mcnt[i]++;
        else m_ecnt = 1'b1;
      end
    end
    if (push || allz) mtmo = 0;
    else if (mtmo < TMO) mtmo++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    b_any = 1'b0; b_logb = '0; b_loge = '0; b_data = '0; b_plen = '0;
  endtask

  task automatic push_logb(input logic [LB-1:0] lb, input logic [DW-1:0] d, input logic [OW-1:0] pl);
    b_any = 1'b1; b_logb = lb; b_data = d; b_plen = pl;
    step();
    b_any = 1'b0; b_logb = '0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    check(name, out_valid, 1'b1);
  endtask

  initial begin
    int n, p0;
    vecs[0] = '{8'h00, 8'hFF, 32'hDEADBEEF, 10'd32, 16'h0000, 10'd56};
    vecs[1] = '{8'h81, 8'h01, 32'h00000001, 10'd0,  16'h4001, 10'd24};
    vecs[2] = '{8'hFF, 8'h00, 32'h12345678, 10'd7,  16'h5555, 10'd31};
    vecs[3] = '{8'h24, 8'h80, 32'h0BADF00D, 10'd10, 16'h0410, 10'd34};

    rstn = 1'b0; b_rdy = 1'b1;
    idle_inputs();
    model_clear();
    @(negedge clk); @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_almful", almful, 1'b0);
    check("rst_err_cnt", err_cnt_oflow, 1'b0);
    check("rst_err_fifo", err_fifo_oflow, 1'b0);
    rstn = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) begin
      b_loge = vecs[k].pre_loge; step(); b_loge = '0;
      push_logb(vecs[k].logb, vecs[k].data, vecs[k].plen);
      wait_valid("vec_valid");
      check("vec_entry", {out_len, out_data},
            {vecs[k].exp_len, vecs[k].data, vecs[k].exp_cnt, vecs[k].logb});
    end

    // Ends on ch0 twice, then a begin on ch2: latency and packing.
    b_loge = 8'h01; step(); b_loge = '0; step();
    b_loge = 8'h01; step(); b_loge = '0; step();
    push_logb(8'h04, 32'hCAFE0001, 10'd20);
    check("t1_lat_early", out_valid, 1'b0);
    step();
    check("t1_lat_vld", out_valid, 1'b1);
    check("t1_entry", {out_len, out_data}, {10'd44, 32'hCAFE0001, 16'h0002, 8'h04});
    step();

    // Same-cycle end is deferred to the following entry.
    b_rdy = 1'b0;
    b_loge = 8'h02; push_logb(8'h02, 32'h11111111, 10'd4); b_loge = '0;
    step(); step(); step();
    push_logb(8'h02, 32'h22222222, 10'd5);
    step(); step();
    check("t2_first", {out_len, out_data}, {10'd28, 32'h11111111, 16'h0000, 8'h02});
    b_rdy = 1'b1; step();
    check("t2_second", {out_len, out_data}, {10'd29, 32'h22222222, 16'h0004, 8'h02});
    step();

    // Saturation flush on ch4.
    b_loge = 8'h10; step(); step(); step(); b_loge = '0;
    wait_valid("t3_valid");
    check("t3_entry", {out_len, out_data}, {10'd24, 32'h0, 16'h0300, 8'h00});
    check("t3_no_oflow", err_cnt_oflow, 1'b0);
    step();

    // Timeout flush for a lone end on ch7.
    b_loge = 8'h80; step(); b_loge = '0;
    for (int j = 0; j < 17; j++) step();
    check("t4_not_yet", out_valid, 1'b0);
    step();
    check("t4_valid", out_valid, 1'b1);
    check("t4_entry", {out_len, out_data}, {10'd24, 32'h0, 16'h4000, 8'h00});
    step();

    // Fill with no drain: almful threshold, end-count loss and overflow.
    b_rdy = 1'b0;
    for (int k = 0; k < DEPTH - THR - 1; k++) push_logb(8'h01, 32'(k), 10'd0);
    step();
    check("almful_below", almful, 1'b0);
    push_logb(8'h01, 32'h1000, 10'd0);
    step();
    check("almful_at", almful, 1'b1);
    for (int k = 0; k < THR; k++) push_logb(8'h02, 32'(k + 200), 10'd1);
    step();
    check("full_no_oflow", err_fifo_oflow, 1'b0);
    b_loge = 8'h01; for (int j = 0; j < 4; j++) step(); b_loge = '0;
    push_logb(8'h04, 32'hBEEF, 10'd2);
    step();
    check("cnt_oflow_set", err_cnt_oflow, 1'b1);
    check("fifo_oflow_set", err_fifo_oflow, 1'b1);
    b_rdy = 1'b1;
    p0 = n_pop; n = 0;
    while (mq.size() != 0 && n < 400) begin step(); n++; end
    check("drain_count", 66'(n_pop - p0), 66'(DEPTH));
    step(); step();
    check("almful_clear", almful, 1'b0);

    // Asynchronous reset in the middle of a drain.
    b_rdy = 1'b0;
    for (int k = 0; k < 10; k++) push_logb(8'h08, 32'(k + 500), 10'd3);
    b_loge = 8'h08; step(); b_loge = '0;
    b_rdy = 1'b1; step(); step(); step();
    #2 rstn = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_err_cnt", err_cnt_oflow, 1'b0);
    check("arst_err_fifo", err_fifo_oflow, 1'b0);
    check("arst_almful", almful, 1'b0);
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    for (int j = 0; j < 4; j++) step();
    check("arst_discarded", out_valid, 1'b0);
    push_logb(8'h01, 32'hA5A5A5A5, 10'd5);
    wait_valid("arst_valid");
    check("arst_entry", {out_len, out_data}, {10'd29, 32'hA5A5A5A5, 16'h0000, 8'h01});
    step();

    // Random traffic with bursts of backpressure.
    for (int c = 0; c < 3000; c++) begin
      if (c % 600 < 300) begin
        b_rdy = ($urandom_range(0, 7) == 0);
        b_any = $urandom_range(0, 1) == 1;
      end else begin
        b_rdy = ($urandom_range(0, 3) != 0);
        b_any = ($urandom_range(0, 3) == 0);
      end
      b_logb = LB'($urandom);
      b_loge = LE'($urandom) & LE'($urandom) & LE'($urandom);
      b_data = $urandom;
      b_plen = OW'($urandom_range(0, DW));
      step();
    end
    idle_inputs();
    b_rdy = 1'b1;
    n = 0;
    while ((mq.size() != 0 || n < 40) && n < 400) begin step(); n++; end
    check("final_empty", 66'(mq.size()), 66'(0));
    check("final_out_valid", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_hb_counting_encoder.md
# rr_hb_counting_encoder

Parametrised successor of the logging-bus happen-before encoder. Buffers standalone transaction ends (loge) as per-channel saturating counts instead of single bits, emits loge-only "flush" packets when a count saturates or a timeout expires, and queues all packets in an almost-full-guarded FIFO toward the writeback stream. Sits between the merge-tree output (packed logb bus) and the record writeback path.

## Interface
Parameters:
- LOGB_CHANNEL_CNT, 8: channels producing transaction begins.
- LOGE_CHANNEL_CNT, 8: channels producing transaction ends.
- LOGB_DATA_WIDTH, 512: packed logb payload width.
- OFFSET_WIDTH, 10: width of length fields; must hold FULL_WIDTH.
- LOGE_CNT_WIDTH, 2: bits per loge counter; MAX = 2**LOGE_CNT_WIDTH-1.
- FIFO_PTR_WIDTH, 7: FIFO depth = 2**FIFO_PTR_WIDTH.
- ALMFUL_THRESHOLD, 2*RECORDER_PIPE_DEPTH+2*MERGE_TREE_HEIGHT+16: free entries at which almful asserts; must be < depth.
- FLUSH_TIMEOUT, 1024: cycles with nonzero counts before forced flush; 0 disables.
- Derived FULL_WIDTH = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT*LOGE_CNT_WIDTH + LOGB_DATA_WIDTH.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- in_logb_valid  in  LOGB_CHANNEL_CNT  per-channel begin strobes.
- in_loge_valid  in  LOGE_CHANNEL_CNT  per-channel end strobes.
- in_any_valid  in  1  packed logb present this cycle.
- in_plogb_data  in  LOGB_DATA_WIDTH  packed logb payload.
- in_plogb_len  in  OFFSET_WIDTH  valid bits in payload.
- in_logb_almful  out  1  backpressure to channel loggers.
- out_valid  out  1  writeback entry valid.
- out_ready  in  1  writeback accepts.
- out_data  out  FULL_WIDTH  LSB→MSB: logb_valid, loge counts (channel 0 lowest), payload.
- out_len  out  OFFSET_WIDTH  valid bits in out_data.
- err_cnt_oflow  out  1  sticky: a loge was lost to saturation.
- err_fifo_oflow  out  1  sticky: push while FIFO full.

## Operation
- Counters cnt[i] (LOGE_CNT_WIDTH) accumulate loge since last push.
- push_logb = in_any_valid. flush_req = any cnt[i]==MAX, or timeout counter == FLUSH_TIMEOUT (nonzero param). push_flush = flush_req & !push_logb & !fifo_full. push = push_logb | push_flush.
- On push: entry carries current cnt[] (loge strictly before this logb); cnt[i] <= in_loge_valid[i] (same-cycle ends deferred to next entry).
- No push, loge[i]: cnt[i] <= cnt[i]+1 if < MAX; at MAX, hold MAX and set err_cnt_oflow.
- logb entry: logb_valid field = in_logb_valid, payload = in_plogb_data, len = in_plogb_len + LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT*LOGE_CNT_WIDTH.
- flush entry: logb_valid=0, payload=0, len = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT*LOGE_CNT_WIDTH.
- Timeout counter: cleared on push or when all cnt==0; increments otherwise, saturates at FLUSH_TIMEOUT.
- push while FIFO full: entry dropped, err_fifo_oflow set; counters still reset per push rule.
- in_logb_almful = free entries <= ALMFUL_THRESHOLD.
- Elaboration $error if OFFSET_WIDTH can't hold FULL_WIDTH or threshold >= depth.

## Timing
- Reset (async, rstn low): cnt=0, timeout=0, errs=0, FIFO empty, out_valid=0, in_logb_almful=0; out_data/out_len don't-care while !out_valid.
- Push→out_valid latency: 2 cycles (first-word-fall-through, one read-pipeline stage).
- out_valid/out_data stable until out_ready; pop on out_valid&out_ready.
- Simultaneous push and pop on full FIFO: pop frees first only if FIFO supports it; otherwise counted as overflow — FIFO used supports simultaneous push/pop at full.
- almful updates 1 cycle after occupancy change.
- Reset mid-operation: all queued entries discarded, state as reset.

## Structure
- Shared package rr_hb_pkg: FULL_WIDTH/len helper functions, entry field offsets, flush-len constant.
- Sub-module: existing ram_fifo_ft (WIDTH=FULL_WIDTH+OFFSET_WIDTH, PTR_WIDTH=FIFO_PTR_WIDTH, WATERMARK=depth-ALMFUL_THRESHOLD, PIPELINE=1).

## Test plan
- loge ch0 at cycles 1,3, logb ch2 at cycle 5 -> one entry, count ch0=2, logb_valid=0b100, len=plogb_len+8+16.
- loge ch1 and logb ch1 same cycle, then logb at +4 -> first entry cnt ch1=0, second cnt ch1=1.
- 3 loge on ch4 (W=2), no logb -> flush entry logb_valid=0, cnt ch4=3, len=24; err_cnt_oflow=0.
- FLUSH_TIMEOUT=16, single loge ch7 -> flush entry at cycle 16 after loge with cnt ch7=1.
- out_ready=0, push 128-ALMFUL_THRESHOLD entries -> in_logb_almful=1; fill 128+1 -> err_fifo_oflow=1, 128 entries drain in order.
- Assert rstn low mid-drain -> out_valid=0 asynchronously, counters 0, errors cleared.
